tdp_mode_bram: RTL



---
 rtl/tdp_mode_bram.sv | 122 ++++++++++++
 1 files changed

// File: rtl/tdp_mode_bram.sv
// True dual-port block RAM with byte enables, selectable read-during-write mode,
// optional output register, per-port valid strobes and a same-address collision flag.
module tdp_mode_bram #(
    parameter int RAM_WIDTH     = 32,
    parameter int RAM_ADDR_BITS = 10,
    parameter int READ_MODE     = 0,
    parameter int OUT_REG       = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [RAM_ADDR_BITS-1:0] addr_a_i,
    input  logic [RAM_ADDR_BITS-1:0] addr_b_i,
    input  logic [RAM_WIDTH-1:0]     data_a_i,
    input  logic [RAM_WIDTH-1:0]     data_b_i,
    input  logic [RAM_WIDTH/8-1:0]   we_a_i,
    input  logic [RAM_WIDTH/8-1:0]   we_b_i,
    input  logic                     en_a_i,
    input  logic                     en_b_i,
    output logic [RAM_WIDTH-1:0]     data_a_o,
    output logic [RAM_WIDTH-1:0]     data_b_o,
    output logic                     valid_a_o,
    output logic                     valid_b_o,
    output logic                     collision_o
);

    localparam int NB    = RAM_WIDTH / 8;
    localparam int DEPTH = 2 ** RAM_ADDR_BITS;

    typedef enum logic [1:0] {
        WRITE_FIRST = 2'd0,
        READ_FIRST  = 2'd1,
        NO_CHANGE   = 2'd2
    } mode_e;

    localparam mode_e MODE = mode_e'(READ_MODE);

    logic [RAM_WIDTH-1:0] mem [DEPTH];

    logic                 wr_a, wr_b, same_addr, collision;
    logic [RAM_WIDTH-1:0] old_a, old_b, new_a, new_b, rd_a, rd_b;
    logic                 ld_a, ld_b;

    logic [RAM_WIDTH-1:0] s1_data_a, s1_data_b;
    logic                 s1_valid_a, s1_valid_b, s1_coll;

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        wr_a      = en_a_i && (|we_a_i);
        wr_b      = en_b_i && (|we_b_i);
        same_addr = (addr_a_i == addr_b_i);
        collision = en_a_i && en_b_i && same_addr && (wr_a || wr_b);
        old_a     = mem[addr_a_i];
        old_b     = mem[addr_b_i];
        new_a     = old_a;
        new_b     = old_b;
        // Final merged word at each port's address; port A wins any byte both ports write.
        for (int k = 0; k < NB; k++) begin
            if (en_b_i && we_b_i[k] && same_addr) new_a[8*k +: 8] = data_b_i[8*k +: 8];
            if (en_a_i && we_a_i[k])              new_a[8*k +: 8] = data_a_i[8*k +: 8];
            if (en_b_i && we_b_i[k])              new_b[8*k +: 8] = data_b_i[8*k +: 8];
            if (en_a_i && we_a_i[k] && same_addr) new_b[8*k +: 8] = data_a_i[8*k +: 8];
        end
        rd_a = (wr_a && MODE == WRITE_FIRST) ? new_a : old_a;
        rd_b = (wr_b && MODE == WRITE_FIRST) ? new_b : old_b;
        ld_a = en_a_i && !(wr_a && MODE == NO_CHANGE);
        ld_b = en_b_i && !(wr_b && MODE == NO_CHANGE);
    end

    // NOTE: the array has no reset; clearing it would prevent block-RAM mapping and
    // reset must leave contents intact anyway.
    always_ff @(posedge clk_i) begin
        // Port A assignments come last so they win on overlapping bytes.
        for (int k = 0; k < NB; k++) begin
            if (en_b_i && we_b_i[k]) mem[addr_b_i][8*k +: 8] <= data_b_i[8*k +: 8];
            if (en_a_i && we_a_i[k]) mem[addr_a_i][8*k +: 8] <= data_a_i[8*k +: 8];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_data_a  <= '0;
            s1_data_b  <= '0;
            s1_valid_a <= 1'b0;
            s1_valid_b <= 1'b0;
            s1_coll    <= 1'b0;
        end else begin
            s1_valid_a <= ld_a;
            s1_valid_b <= ld_b;
            s1_coll    <= collision;
            if (ld_a) s1_data_a <= rd_a;
            if (ld_b) s1_data_b <= rd_b;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    data_a_o    <= '0;
                    data_b_o    <= '0;
                    valid_a_o   <= 1'b0;
                    valid_b_o   <= 1'b0;
                    collision_o <= 1'b0;
                end else begin
                    valid_a_o   <= s1_valid_a;
                    valid_b_o   <= s1_valid_b;
                    collision_o <= s1_coll;
                    if (s1_valid_a) data_a_o <= s1_data_a;
                    if (s1_valid_b) data_b_o <= s1_data_b;
                end
            end
        end else begin : g_direct
            assign data_a_o    = s1_data_a;
            assign data_b_o    = s1_data_b;
            assign valid_a_o   = s1_valid_a;
            assign valid_b_o   = s1_valid_b;
            assign collision_o = s1_coll;
        end
    endgenerate

endmodule
